shift_deserializer: RTL

- Serial-in, parallel-out receiver for the bit stream produced by the team's 8-bit right-shift register. That register emits its LSB first on its serial output, one bit per clock.
- Assembles WIDTH accepted bits into a parallel word and presents it on a valid/ready output port.
- Has a separate output holding register, so collection of the next word continues while the current word waits.
- Sits between the shifter's serial output and downstream parallel consumers (LED display, compare logic).

---
 rtl/shift_deserializer_pkg.sv | 20 ++
 rtl/shift_deserializer_core.sv | 64 ++++++
 rtl/shift_deserializer.sv | 79 +++++++
 3 files changed

// File: rtl/shift_deserializer_pkg.sv
// ----------------------------------------------------------------------------
// shift_deserializer_pkg
// Constants and helpers used by the serial-to-parallel receiver.
//   DEFAULT_WIDTH       : default word width (matches the 8-bit transmitter)
//   BIT_ORDER_LSB_FIRST : first received bit lands in word bit 0
//   BIT_ORDER_MSB_FIRST : first received bit lands in word bit WIDTH-1
//   cnt_width()         : width of a counter able to hold 0..WIDTH
// ----------------------------------------------------------------------------
package shift_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam bit BIT_ORDER_LSB_FIRST = 1'b1;
    localparam bit BIT_ORDER_MSB_FIRST = 1'b0;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_deserializer_core.sv
// ----------------------------------------------------------------------------
// deser_shift_core
// Shift register plus bit counter. Collects accepted serial bits and offers
// the completed word on the edge that accepts the last bit.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   ser_in      : serial data bit
//   ser_valid   : ser_in is taken on this edge
//   clr         : synchronous abort of the partial word
//   bit_cnt     : bits collected in the current word
//   candidate   : assembled word including the bit being accepted now
//   complete    : high during the cycle whose edge accepts the last bit
// ----------------------------------------------------------------------------
module deser_shift_core
    import shift_deserializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = BIT_ORDER_LSB_FIRST
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ser_in,
    input  logic                        ser_valid,
    input  logic                        clr,
    output logic [cnt_width(WIDTH)-1:0] bit_cnt,
    output logic [WIDTH-1:0]            candidate,
    output logic                        complete
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;

    generate
        if (LSB_FIRST == BIT_ORDER_LSB_FIRST) begin : g_lsb_first
            // Right shift, same direction as the transmitter, so the first
            // bit ends up in bit 0 after WIDTH shifts.
            assign shift_next = {ser_in, shift_reg[WIDTH-1:1]};
        end else begin : g_msb_first
            assign shift_next = {shift_reg[WIDTH-2:0], ser_in};
        end
    endgenerate

    // The candidate is the post-shift value so the final bit is included
    // without waiting an extra cycle.
    assign candidate = shift_next;
    assign complete  = ser_valid && !clr && (bit_cnt == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clr) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (ser_valid) begin
            shift_reg <= shift_next;
            bit_cnt   <= complete ? '0 : bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// ----------------------------------------------------------------------------
// shift_deserializer
// Serial-in, parallel-out receiver with a holding register and valid/ready
// output, so collection of the next word continues while a word waits.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   ser_in      : serial data bit
//   ser_valid   : ser_in is sampled on this edge
//   clr         : synchronous abort; drops the partial word, clears overrun
//   par_out     : assembled word (holding register)
//   par_valid   : par_out holds an unconsumed word
//   par_ready   : consumer takes par_out on an edge where par_valid=1
//   busy        : a partial word is in progress
//   bit_cnt     : bits collected in the current word
//   overrun     : sticky, a completed word was dropped
// ----------------------------------------------------------------------------
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = BIT_ORDER_LSB_FIRST
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ser_in,
    input  logic                        ser_valid,
    input  logic                        clr,
    output logic [WIDTH-1:0]            par_out,
    output logic                        par_valid,
    input  logic                        par_ready,
    output logic                        busy,
    output logic [cnt_width(WIDTH)-1:0] bit_cnt,
    output logic                        overrun
);

    logic [WIDTH-1:0] candidate;
    logic             complete;

    deser_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .clr       (clr),
        .bit_cnt   (bit_cnt),
        .candidate (candidate),
        .complete  (complete)
    );

    assign busy = (bit_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_out   <= '0;
            par_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A word can be loaded whenever the holding register is empty or
            // is being consumed on this same edge (no bubble on back-to-back).
            if (complete && (!par_valid || par_ready)) begin
                par_out   <= candidate;
                par_valid <= 1'b1;
            end else if (par_valid && par_ready) begin
                par_valid <= 1'b0;
            end

            // complete is already suppressed by clr, so clr always wins.
            if (clr) begin
                overrun <= 1'b0;
            end else if (complete && par_valid && !par_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
